unary_binary_mac_4: RTL and testbench

//   Unary-binary multiply-accumulate: out = a*b + c on unsigned operands.

---
 rtl/unary_binary_mac_4_if.sv | 22 ++
 rtl/unary_binary_mac_4.sv | 104 ++++++++++
 tb/tb_unary_binary_mac_4.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/unary_binary_mac_4_if.sv
// Request/result bundle for unary_binary_mac_4: operands and valid in, ready and result out.
// The master side drives operands; the slave side (the MAC) returns the result.
interface unary_binary_mac_4_if #(
  parameter int N = 4
);
  logic           valid;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   c;
  logic           ready;
  logic [2*N-1:0] out;

  modport master (
    output valid, a, b, c,
    input  ready, out
  );

  modport slave (
    input  valid, a, b, c,
    output ready, out
  );
endinterface

// File: rtl/unary_binary_mac_4.sv
// Unary-binary MAC: out = a*b + c. Operand a becomes a thermometer stream (counter_out < a_reg)
// that gates b into an accumulator preloaded with c. Optional macro UB_MAC_EARLY_DONE_EN ends RUN at counter_out == a_reg.
module unary_binary_mac_4 #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  unary_binary_mac_4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [N-1:0] CNT_LAST = '1;

  state_e         state_q, state_d;
  logic [N-1:0]   a_reg, b_reg, c_reg, counter_out;
  logic [N-1:0]   a_d, b_d, c_d, counter_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] out_q, out_d;
  logic           ready_q, ready_d;

  logic           unary;
  logic [N-1:0]   unary_out;
  logic           last;

  assign unary     = (counter_out < a_reg);
  assign unary_out = unary ? b_reg : '0;

`ifdef UB_MAC_EARLY_DONE_EN
  // Every add past counter_out == a_reg would be zero, so stop there.
  assign last = (counter_out == a_reg);
`else
  // Fixed schedule: adds happen for counter 0..2^N-2, result moves out at 2^N-1.
  assign last = (counter_out == CNT_LAST);
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    a_d       = a_reg;
    b_d       = b_reg;
    c_d       = c_reg;
    counter_d = counter_out;
    acc_d     = acc_q;
    out_d     = out_q;
    ready_d   = ready_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.valid) begin
          a_d       = bus.a;
          b_d       = bus.b;
          c_d       = bus.c;
          acc_d     = {{N{1'b0}}, bus.c};
          counter_d = '0;
          ready_d   = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (last) begin
          out_d   = acc_q;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          acc_d     = acc_q + {{N{1'b0}}, unary_out};
          counter_d = counter_out + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      counter_out <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_reg       <= a_d;
      b_reg       <= b_d;
      c_reg       <= c_d;
      counter_out <= counter_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.out   = out_q;

endmodule

// File: tb/tb_unary_binary_mac_4.sv
// Directed bench for unary_binary_mac_4: vector table of single operations plus
// hand-written sequences for valid-during-RUN, valid-in-DONE and mid-run reset.
module tb_unary_binary_mac_4;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [2*N-1:0] exp_out;
  } vec_t;

  logic clk;
  logic reset;

  int n_vec;
  int n_miss;

  unary_binary_mac_4_if #(.N(N)) mac_if ();

  unary_binary_mac_4 #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mac_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [N-1:0] a);
`ifdef UB_MAC_EARLY_DONE_EN
    return int'(a) + 1;
`else
    return 16;
`endif
  endfunction

  // Drive one valid cycle; returns with valid low, one edge (the capture edge) elapsed.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c,
                          input string name);
    @(negedge clk);
    mac_if.valid = 1'b1;
    mac_if.a     = a;
    mac_if.b     = b;
    mac_if.c     = c;
    @(posedge clk);
    #1;
    check({name, "_ready_low_after_capture"}, 16'(mac_if.ready), 16'd0);
    @(negedge clk);
    mac_if.valid = 1'b0;
  endtask

  // Wait (bounded) for ready; 'elapsed' counts edges already past the capture edge.
  task automatic wait_done(input logic [2*N-1:0] exp_out, input int exp_lat, input int elapsed,
                           input logic [2*N-1:0] old_out, input string name);
    int  cyc;
    bit  held;
    cyc  = elapsed;
    held = 1'b1;
    while (!mac_if.ready && cyc < 40) begin
      if (mac_if.out !== old_out) held = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, 16'(cyc), 16'(exp_lat));
    check({name, "_out"}, 16'(mac_if.out), 16'(exp_out));
    check({name, "_out_held_during_run"}, 16'(held), 16'd1);
  endtask

  task automatic run_op(input vec_t v, input string name);
    logic [2*N-1:0] old_out;
    @(negedge clk);
    old_out = mac_if.out;
    start_op(v.a, v.b, v.c, name);
    wait_done(v.exp_out, exp_latency(v.a), 0, old_out, name);
  endtask

  initial begin
    vec_t vecs[9];
    logic [2*N-1:0] old_out;

    n_vec  = 0;
    n_miss = 0;

    vecs[0] = '{a: 4'd15, b: 4'd15, c: 4'd15, exp_out: 8'd240};
    vecs[1] = '{a: 4'd3,  b: 4'd7,  c: 4'd6,  exp_out: 8'd27};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  c: 4'd5,  exp_out: 8'd5};
    vecs[3] = '{a: 4'd1,  b: 4'd1,  c: 4'd0,  exp_out: 8'd1};
    vecs[4] = '{a: 4'd15, b: 4'd0,  c: 4'd0,  exp_out: 8'd0};
    vecs[5] = '{a: 4'd5,  b: 4'd10, c: 4'd3,  exp_out: 8'd53};
    vecs[6] = '{a: 4'd15, b: 4'd1,  c: 4'd15, exp_out: 8'd30};
    vecs[7] = '{a: 4'd2,  b: 4'd3,  c: 4'd1,  exp_out: 8'd7};
    vecs[8] = '{a: 4'd14, b: 4'd15, c: 4'd0,  exp_out: 8'd210};

    reset        = 1'b1;
    mac_if.valid = 1'b0;
    mac_if.a     = '0;
    mac_if.b     = '0;
    mac_if.c     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 16'(mac_if.ready), 16'd0);
    check("reset_out", 16'(mac_if.out), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle with valid low: nothing should start.
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_ready", 16'(mac_if.ready), 16'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // valid pulsed while RUN is ignored; the first operation's result stands.
    @(negedge clk);
    old_out = mac_if.out;
    start_op(4'd2, 4'd3, 4'd1, "ignore");
    @(posedge clk);
    @(negedge clk);
    mac_if.valid = 1'b1;
    mac_if.a     = 4'd15;
    mac_if.b     = 4'd15;
    mac_if.c     = 4'd15;
    @(posedge clk);
    #1;
    @(negedge clk);
    mac_if.valid = 1'b0;
    wait_done(8'd7, exp_latency(4'd2), 2, old_out, "ignore");
    repeat (20) @(posedge clk);
    #1;
    check("ignore_no_queued_ready", 16'(mac_if.ready), 16'd1);
    check("ignore_no_queued_out", 16'(mac_if.out), 16'd7);

    // valid accepted directly from DONE; ready falls at the capture edge.
    start_op(4'd4, 4'd4, 4'd0, "from_done");
    wait_done(8'd16, exp_latency(4'd4), 0, 8'd7, "from_done");

    // Reset mid-RUN aborts the operation with no result.
    start_op(4'd15, 4'd15, 4'd15, "abort");
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 16'(mac_if.ready), 16'd0);
    check("abort_out", 16'(mac_if.out), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_late_ready", 16'(mac_if.ready), 16'd0);
    check("abort_no_late_out", 16'(mac_if.out), 16'd0);
    run_op(vecs[1], "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
